// File: rtl/cond_writeback_pkg.sv
// Shared definitions for the conditional writeback stage.
//   - ARM condition-field encodings (EQ..AL)
//   - bit positions of N, Z, C, V inside the 4-bit flag vector {N,Z,C,V}
//   - writeback sequencer states
package cond_writeback_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // IDLE: accepting instructions. HI: issuing the high word of a 64-bit result.
  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_t;

endpackage

// File: rtl/cond_writeback_cond_check.sv
// Combinational ARM condition evaluator.
// Ports:
//   cond    in  4  condition field of the instruction
//   flags   in  4  registered {N,Z,C,V}
//   cond_ex out 1  condition passed
module cond_check
  import cond_writeback_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      // AL and the unused 1111 encoding both execute unconditionally
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_writeback.sv
// Conditional writeback stage following the ALU.
// Holds the NZCV flag register, evaluates the condition field against it and
// gates register/memory/PC writes. 64-bit multiply results are written as two
// register-file writes (low word in the accept cycle, high word the next
// cycle) while in_ready is held low for that one extra cycle.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid / in_ready    instruction handshake (in_ready high only in IDLE)
//   Cond, ALUFlags, FlagW  condition field, new ALU flags, flag-update mask
//   RegW, MemW, PCS        instruction write intents
//   NoWrite, LongOp        suppress register write / 64-bit result
//   Result, Long           low and high ALU results
//   RdLo, RdHi             destinations for Result and Long
//   RegWrite, WA3, WD3     register-file write port
//   MemWrite, PCSrc        memory write enable, PC-from-result select
//   Flags, CondEx          registered {N,Z,C,V}, condition passed
module cond_writeback
  import cond_writeback_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RBITS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             PCS,
  input  logic             NoWrite,
  input  logic             LongOp,
  input  logic [WIDTH-1:0] Result,
  input  logic [WIDTH-1:0] Long,
  input  logic [RBITS-1:0] RdLo,
  input  logic [RBITS-1:0] RdHi,
  output logic             RegWrite,
  output logic [RBITS-1:0] WA3,
  output logic [WIDTH-1:0] WD3,
  output logic             MemWrite,
  output logic             PCSrc,
  output logic [3:0]       Flags,
  output logic             CondEx
);

  state_t           state, state_next;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] hi_data;
  logic [RBITS-1:0] hi_addr;
  logic             accept;
  logic             exec;
  logic             lo_write;

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (CondEx)
  );

  assign Flags    = flags_q;
  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  // Condition is judged on the flags before this instruction's own update.
  assign exec     = accept & CondEx;
  assign lo_write = exec & RegW & !NoWrite;

  always_comb begin
    state_next = state;
    RegWrite   = 1'b0;
    WA3        = RdLo;
    WD3        = Result;
    MemWrite   = 1'b0;
    PCSrc      = 1'b0;
    case (state)
      IDLE: begin
        RegWrite = lo_write;
        MemWrite = exec & MemW;
        PCSrc    = exec & PCS;
        if (lo_write && LongOp) state_next = HI;
      end
      HI: begin
        RegWrite   = 1'b1;
        WA3        = hi_addr;
        WD3        = hi_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Writes must not escape while reset is held, even before the state
    // register has had a chance to settle.
    if (!reset_n) begin
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      PCSrc    = 1'b0;
      WA3      = '0;
      WD3      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // exec is only ever true in IDLE, so HI never touches the flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
    end else if (exec) begin
      if (FlagW[1]) begin
        flags_q[FLAG_N] <= ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (FlagW[0]) begin
        flags_q[FLAG_C] <= ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_data <= '0;
      hi_addr <= '0;
    end else if (state == IDLE && lo_write && LongOp) begin
      hi_data <= Long;
      hi_addr <= RdHi;
    end
  end

endmodule

// File: tb/tb_cond_writeback.sv
module tb_cond_writeback;

  localparam int WIDTH = 32;
  localparam int RBITS = 4;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             RegW, MemW, PCS, NoWrite, LongOp;
  logic [WIDTH-1:0] Result, Long;
  logic [RBITS-1:0] RdLo, RdHi;
  logic             RegWrite;
  logic [RBITS-1:0] WA3;
  logic [WIDTH-1:0] WD3;
  logic             MemWrite, PCSrc;
  logic [3:0]       Flags;
  logic             CondEx;

  int errors = 0;
  int checks = 0;

  cond_writeback #(.WIDTH(WIDTH), .RBITS(RBITS)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .RegW(RegW), .MemW(MemW),
    .PCS(PCS), .NoWrite(NoWrite), .LongOp(LongOp), .Result(Result), .Long(Long),
    .RdLo(RdLo), .RdHi(RdHi), .RegWrite(RegWrite), .WA3(WA3), .WD3(WD3),
    .MemWrite(MemWrite), .PCSrc(PCSrc), .Flags(Flags), .CondEx(CondEx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    in_valid = 0; Cond = 4'b1110; ALUFlags = 0; FlagW = 0;
    RegW = 0; MemW = 0; PCS = 0; NoWrite = 0; LongOp = 0;
    Result = 0; Long = 0; RdLo = 0; RdHi = 0;
  endtask

  // advance to 1ns past the next rising edge
  task automatic step();
    @(posedge clk); #1;
  endtask

  // issue a flag-setting op with no writes and advance one cycle
  task automatic set_flags(input logic [3:0] f);
    clear_inputs();
    in_valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f; NoWrite = 1;
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    in_valid = 1; RegW = 1; MemW = 1; PCS = 1; Result = 32'h1234; RdLo = 4'd5;
    #2;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
    checks++; if (MemWrite !== 1'b0 || PCSrc !== 1'b0) begin errors++; $display("FAIL reset_mem_pc got=%b%b exp=00", MemWrite, PCSrc); end
    checks++; if (WA3 !== 4'd0 || WD3 !== 32'd0) begin errors++; $display("FAIL reset_wa3_wd3 got=%h/%h exp=0/0", WA3, WD3); end
    step();
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    clear_inputs();
    reset_n = 1;
    step();
  endtask

  task automatic test_cmp_then_eq();
    clear_inputs();
    in_valid = 1; Cond = 4'b1110; FlagW = 2'b11; NoWrite = 1; RegW = 1; ALUFlags = 4'b0100;
    #2;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL cmp_regwrite got=%b exp=0", RegWrite); end
    step();
    checks++; if (Flags !== 4'b0100) begin errors++; $display("FAIL cmp_flags got=%b exp=0100", Flags); end
    clear_inputs();
    in_valid = 1; Cond = 4'b0000; RegW = 1; Result = 32'h5; RdLo = 4'd7;
    #2;
    checks++; if (RegWrite !== 1'b1 || WA3 !== 4'd7 || WD3 !== 32'h5) begin
      errors++; $display("FAIL eq_write got=%b/%h/%h exp=1/7/00000005", RegWrite, WA3, WD3); end
    step();
    clear_inputs();
  endtask

  task automatic test_mem_pc_gating();
    set_flags(4'b0000);
    in_valid = 1; Cond = 4'b0001; MemW = 1;
    #2;
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL ne_memwrite got=%b exp=1", MemWrite); end
    step();
    clear_inputs(); in_valid = 1; Cond = 4'b0000; MemW = 1;
    #2;
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL eq_memwrite got=%b exp=0", MemWrite); end
    step();
    clear_inputs(); in_valid = 1; Cond = 4'b0000; PCS = 1;
    #2;
    checks++; if (PCSrc !== 1'b0) begin errors++; $display("FAIL eq_pcsrc got=%b exp=0", PCSrc); end
    step();
    clear_inputs(); in_valid = 1; Cond = 4'b1110; PCS = 1;
    #2;
    checks++; if (PCSrc !== 1'b1) begin errors++; $display("FAIL al_pcsrc got=%b exp=1", PCSrc); end
    step();
    clear_inputs();
  endtask

  task automatic test_long_op();
    clear_inputs();
    in_valid = 1; Cond = 4'b1110; RegW = 1; LongOp = 1;
    Result = 32'h00000001; Long = 32'hFFFFFFFE; RdLo = 4'd2; RdHi = 4'd3;
    #2;
    checks++; if (RegWrite !== 1'b1 || WA3 !== 4'd2 || WD3 !== 32'h1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL long_c0 got=%b/%h/%h rdy=%b exp=1/2/00000001 rdy=1", RegWrite, WA3, WD3, in_ready); end
    step();
    // a fresh instruction in the HI cycle must be ignored entirely
    clear_inputs();
    in_valid = 1; Cond = 4'b1110; RegW = 1; MemW = 1; PCS = 1; RdLo = 4'd9;
    Result = 32'hAA; FlagW = 2'b11; ALUFlags = 4'b1111;
    #2;
    checks++; if (RegWrite !== 1'b1 || WA3 !== 4'd3 || WD3 !== 32'hFFFFFFFE || in_ready !== 1'b0) begin
      errors++; $display("FAIL long_c1 got=%b/%h/%h rdy=%b exp=1/3/fffffffe rdy=0", RegWrite, WA3, WD3, in_ready); end
    checks++; if (MemWrite !== 1'b0 || PCSrc !== 1'b0) begin
      errors++; $display("FAIL long_c1_mem_pc got=%b%b exp=00", MemWrite, PCSrc); end
    step();
    clear_inputs();
    #2;
    checks++; if (in_ready !== 1'b1 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL long_c2 got rdy=%b rw=%b exp rdy=1 rw=0", in_ready, RegWrite); end
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL long_flags_held got=%b exp=0000", Flags); end
    // same destination for both halves: low then high
    in_valid = 1; Cond = 4'b1110; RegW = 1; LongOp = 1;
    Result = 32'h11; Long = 32'h22; RdLo = 4'd4; RdHi = 4'd4;
    #1;
    checks++; if (WA3 !== 4'd4 || WD3 !== 32'h11) begin errors++; $display("FAIL same_rd_lo got=%h/%h exp=4/00000011", WA3, WD3); end
    step();
    clear_inputs();
    #2;
    checks++; if (RegWrite !== 1'b1 || WA3 !== 4'd4 || WD3 !== 32'h22) begin
      errors++; $display("FAIL same_rd_hi got=%b/%h/%h exp=1/4/00000022", RegWrite, WA3, WD3); end
    step();
  endtask

  task automatic test_gt_and_nowrite();
    set_flags(4'b1001);
    Cond = 4'b1100;
    #2;
    checks++; if (CondEx !== 1'b1) begin errors++; $display("FAIL gt_pass got=%b exp=1", CondEx); end
    set_flags(4'b1101);
    in_valid = 1; Cond = 4'b1100; RegW = 1; LongOp = 1; Result = 32'h7; Long = 32'h8; RdLo = 4'd1; RdHi = 4'd2;
    #2;
    checks++; if (CondEx !== 1'b0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL gt_fail got cx=%b rw=%b exp cx=0 rw=0", CondEx, RegWrite); end
    step();
    clear_inputs();
    #2;
    checks++; if (in_ready !== 1'b1 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL gt_no_hi got rdy=%b rw=%b exp rdy=1 rw=0", in_ready, RegWrite); end
    // NoWrite on a long op: no writes, no HI, flags still update
    in_valid = 1; Cond = 4'b1110; RegW = 1; NoWrite = 1; LongOp = 1; FlagW = 2'b11; ALUFlags = 4'b0010;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL nowrite_long_rw got=%b exp=0", RegWrite); end
    step();
    clear_inputs();
    #2;
    checks++; if (in_ready !== 1'b1 || RegWrite !== 1'b0 || Flags !== 4'b0010) begin
      errors++; $display("FAIL nowrite_long_after got rdy=%b rw=%b f=%b exp rdy=1 rw=0 f=0010", in_ready, RegWrite, Flags); end
    step();
  endtask

  task automatic test_reset_in_hi();
    clear_inputs();
    in_valid = 1; Cond = 4'b1110; RegW = 1; LongOp = 1; FlagW = 2'b11; ALUFlags = 4'b1010;
    Result = 32'h3; Long = 32'hDEAD; RdLo = 4'd5; RdHi = 4'd6;
    step();
    clear_inputs();
    #2;
    checks++; if (RegWrite !== 1'b1 || WA3 !== 4'd6 || Flags !== 4'b1010) begin
      errors++; $display("FAIL pre_reset_hi got=%b/%h f=%b exp=1/6 f=1010", RegWrite, WA3, Flags); end
    reset_n = 0;
    #1;
    checks++; if (RegWrite !== 1'b0 || WA3 !== 4'd0 || WD3 !== 32'd0 || Flags !== 4'b0000) begin
      errors++; $display("FAIL reset_in_hi got=%b/%h/%h f=%b exp=0/0/0 f=0000", RegWrite, WA3, WD3, Flags); end
    step();
    reset_n = 1;
    #2;
    checks++; if (in_ready !== 1'b1 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL after_reset_hi got rdy=%b rw=%b exp rdy=1 rw=0", in_ready, RegWrite); end
    step();
  endtask

  task automatic test_partial_flags();
    clear_inputs();
    in_valid = 1; Cond = 4'b1110; FlagW = 2'b01; ALUFlags = 4'b1111;
    step();
    checks++; if (Flags !== 4'b0011) begin errors++; $display("FAIL flagw01 got=%b exp=0011", Flags); end
    clear_inputs();
    in_valid = 1; Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1000;
    step();
    checks++; if (Flags !== 4'b1011) begin errors++; $display("FAIL flagw10 got=%b exp=1011", Flags); end
    clear_inputs();
  endtask

  task automatic test_old_flags_eval();
    // Flags=1011 (Z=0): NE passes although this op sets Z
    clear_inputs();
    in_valid = 1; Cond = 4'b0001; RegW = 1; Result = 32'h99; RdLo = 4'd8; FlagW = 2'b11; ALUFlags = 4'b0100;
    #2;
    checks++; if (CondEx !== 1'b1 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL old_flags_eval got cx=%b rw=%b exp cx=1 rw=1", CondEx, RegWrite); end
    step();
    checks++; if (Flags !== 4'b0100) begin errors++; $display("FAIL old_flags_update got=%b exp=0100", Flags); end
    clear_inputs();
    step();
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    test_reset();
    test_cmp_then_eq();
    test_mem_pc_gating();
    test_long_op();
    test_gt_and_nowrite();
    test_reset_in_hi();
    test_partial_flags();
    test_old_flags_eval();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cond_writeback.md
Name: cond_writeback

Overview:
- Stage directly downstream of the ALU in the ARM-style datapath.
- Holds the NZCV flag register and evaluates the 4-bit instruction condition field against it.
- Gates register, memory and PC writes on the condition result.
- Sequences the two register-file writes needed by 64-bit multiply results (low word, then high word), stalling upstream for one cycle.

Parameters:
- WIDTH, 32, datapath width of Result, Long and WD3.
- RBITS, 4, register-address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present this cycle
- in_ready  out  1  stage can accept; equals (state==IDLE)
- Cond  in  4  ARM condition field
- ALUFlags  in  4  {N,Z,C,V} from ALU for the current instruction
- FlagW  in  2  [1] update N,Z; [0] update C,V
- RegW  in  1  instruction writes a register
- MemW  in  1  instruction writes memory
- PCS  in  1  instruction writes PC
- NoWrite  in  1  suppress register write (CMP/TST class)
- LongOp  in  1  64-bit result (SMUL/UMUL)
- Result  in  WIDTH  ALU low result
- Long  in  WIDTH  ALU high result
- RdLo  in  RBITS  destination for Result
- RdHi  in  RBITS  destination for Long (used only when LongOp)
- RegWrite  out  1  register-file write enable
- WA3  out  RBITS  register-file write address
- WD3  out  WIDTH  register-file write data
- MemWrite  out  1  memory write enable
- PCSrc  out  1  select ALU result as next PC
- Flags  out  4  current registered {N,Z,C,V}
- CondEx  out  1  condition passed (combinational, from registered Flags)

Behaviour:
- Reset (async, reset_n low): Flags=0000, state=IDLE, HI latches cleared.
  - While reset_n is low, RegWrite, MemWrite and PCSrc are forced to 0, WA3=0 and WD3=0.
- Condition decode uses registered Flags, before any update by the current instruction:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 treated as 1.
- accept = in_valid & in_ready; exec = accept & CondEx.
- Flag update at the rising edge when exec:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - Bits not selected hold their value.
- State IDLE, combinational outputs:
  - RegWrite = exec & RegW & !NoWrite.
  - WA3 = RdLo, WD3 = Result.
  - MemWrite = exec & MemW.
  - PCSrc = exec & PCS.
- IDLE -> HI when exec & RegW & !NoWrite & LongOp.
  - Latch Long into hi_data and RdHi into hi_addr at that edge.
- State HI:
  - in_ready=0; in_valid and all instruction inputs ignored; no flag update.
  - RegWrite=1, WA3=hi_addr, WD3=hi_data; MemWrite=0, PCSrc=0.
  - Next edge -> IDLE.
- Latency:
  - Normal op: writes in the accept cycle, zero added latency.
  - Long op: occupies two cycles; in_ready low for exactly one cycle.
- Boundaries:
  - Failed condition on a LongOp: no writes, no HI entry.
  - RdLo==RdHi: both writes issue; the high word lands last and wins.
  - NoWrite with LongOp: no writes, no HI entry; flags still update per FlagW.
  - Reset asserted in HI: the pending high write is dropped.
  - Flags update and condition evaluation in the same cycle: evaluation sees the old flags.

Decomposition:
- Shared package holds:
  - condition-code constants (EQ..AL);
  - flag bit indices N=3, Z=2, C=1, V=0;
  - state enum {IDLE, HI}.
- Sub-module cond_check: combinational, Cond + Flags -> CondEx.

Test Plan:
1. Reset, then issue CMP-like op (FlagW=11, NoWrite=1, ALUFlags=0100) -> Flags=0100, RegWrite=0; next op Cond=EQ, RegW=1, Result=0x5 -> RegWrite=1, WA3=RdLo, WD3=5.
2. Flags=0000, Cond=NE, MemW=1 -> MemWrite=1; Cond=EQ, MemW=1 -> MemWrite=0; Cond=EQ, PCS=1 -> PCSrc=0.
3. UMUL, LongOp=1, Result=0x00000001, Long=0xFFFFFFFE, RdLo=2, RdHi=3:
   - cycle0: WA3=2, WD3=1, in_ready=1.
   - cycle1: WA3=3, WD3=FFFFFFFE, in_ready=0; a new in_valid presented in cycle1 causes no write.
4. Cond=GT with Flags N=1, V=1, Z=0 -> CondEx=1; with Z=1 -> CondEx=0, and a LongOp stays in IDLE with RegWrite=0.
5. Long op issued, reset_n dropped mid-HI -> RegWrite=0 immediately, Flags=0000; after release state is IDLE and in_ready=1.
6. FlagW=01, ALUFlags=1111, prior Flags=0000 -> Flags=0011 (N,Z held).
